// File: rtl/boot_uart_transmitter_if.sv
// Byte handshake between the boot/debug producer and the UART transmitter.
// The producer drives byte_data/byte_valid; the transmitter answers with byte_ready.
interface boot_uart_transmitter_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/boot_uart_transmitter.sv
// Boot UART transmitter: 8-N-1 (or 8-N-2) serialiser with a one-byte holding register.
// Optional macro BOOT_UART_TX_PARITY_EN inserts an even-parity symbol (8-E-1).
//
// state    | meaning
// S_IDLE   | line idle (tx=1), waiting for the holding register to fill
// S_START  | start bit (tx=0)
// S_DATA   | data bits, LSB first, bit_idx_q selects the bit on the line
// S_PARITY | even parity over the byte (only with BOOT_UART_TX_PARITY_EN)
// S_STOP   | stop bit(s) (tx=1); chains straight into S_START if a byte is pending
module boot_uart_transmitter #(
    parameter int unsigned clk_frequency = 50_000_000,
    parameter int unsigned baud_rate     = 115200,
    parameter int unsigned stop_bits     = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    boot_uart_transmitter_if.slave    bus,
    output logic                      tx,
    output logic                      busy
);

    localparam int unsigned CYC = clk_frequency / baud_rate;
    localparam int unsigned CW  = $clog2(CYC + 1);
    localparam logic [CW-1:0] CYC_LD  = CW'(CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic LAST_STOP_IDX    = (stop_bits == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef BOOT_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;

    logic          sym_end;
    logic          take;
    logic [2:0]    nxt_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    // tx_d always carries the level of the symbol the FSM is entering, so tx stays a pure flop output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        take        = 1'b0;
        sym_end     = (cnt_q == CNT_ONE);
        nxt_idx     = bit_idx_q + 3'd1;

        if (state_q != S_IDLE) begin
            cnt_d = sym_end ? CYC_LD : (cnt_q - CNT_ONE);
        end

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q) take = 1'b1;
            end
            S_START: begin
                if (sym_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (sym_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef BOOT_UART_TX_PARITY_EN
                        state_d    = S_PARITY;
                        tx_d       = ^shift_q;
`else
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        bit_idx_d = nxt_idx;
                        tx_d      = shift_q[nxt_idx];
                    end
                end
            end
`ifdef BOOT_UART_TX_PARITY_EN
            S_PARITY: begin
                if (sym_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (sym_end) begin
                    if (stop_idx_q == LAST_STOP_IDX) begin
                        if (hold_full_q) begin
                            take = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Holding-to-shift transfer; a fresh byte may land in the holding register on the same edge.
        if (take) begin
            state_d     = S_START;
            cnt_d       = CYC_LD;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
        end

        if (bus.byte_valid && !hold_full_q) begin
            hold_d      = bus.byte_data;
            hold_full_d = 1'b1;
        end
    end

    assign bus.byte_ready = ~hold_full_q;
    assign tx             = tx_q;
    assign busy           = (state_q != S_IDLE) | hold_full_q;

endmodule

// File: tb/tb_boot_uart_transmitter.sv
// Bench for boot_uart_transmitter at 10 clocks per bit: per-cycle compare against a
// symbol-queue line model, a line decoder, and hand-computed frame expectations.
module tb_boot_uart_transmitter;

    localparam int CYC = 10;
`ifdef BOOT_UART_TX_PARITY_EN
    localparam int SYMS = 11;
`else
    localparam int SYMS = 10;
`endif
    localparam int STOP_CENTER = 10 * (SYMS - 1) + 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx, busy;

    boot_uart_transmitter_if bus();

    boot_uart_transmitter #(
        .clk_frequency(1000),
        .baud_rate(100),
        .stop_bits(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=expired required=event at %0t", name, $time);
    endtask

    // Line model: every clock of every pending symbol, front = level currently on the line.
    bit         line_q[$];
    bit         m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;

    function automatic void push_frame(input logic [7:0] b);
        bit syms[$];
        syms.push_back(1'b0);
        for (int i = 0; i < 8; i++) syms.push_back(b[i]);
`ifdef BOOT_UART_TX_PARITY_EN
        syms.push_back(^b);
`endif
        syms.push_back(1'b1);
        foreach (syms[s]) for (int j = 0; j < CYC; j++) line_q.push_back(syms[s]);
    endfunction

    initial begin
        bit acc;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                line_q.delete();
                m_full = 1'b0;
            end else begin
                acc = (bus.byte_valid === 1'b1) && !m_full;
                if (line_q.size() > 0) void'(line_q.pop_front());
                if (line_q.size() == 0 && m_full) begin
                    push_frame(m_hold);
                    m_full = 1'b0;
                end
                if (acc) begin
                    m_full = 1'b1;
                    m_hold = bus.byte_data;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_tx", tx, (line_q.size() > 0) ? line_q[0] : 1'b1);
            check("cmp_ready", bus.byte_ready, !m_full);
            check("cmp_busy", busy, (line_q.size() > 0) || m_full);
        end
    end

    // Line decoder: samples symbol centres after a start edge.
    logic [7:0] dec_q[$];
`ifdef BOOT_UART_TX_PARITY_EN
    logic dec_par = 1'b0;
`endif
    initial begin
        int   cnt;
        bit   act;
        logic [7:0] sh;
        cnt = 0;
        act = 1'b0;
        sh  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) sh[(cnt - 15) / 10] = tx;
`ifdef BOOT_UART_TX_PARITY_EN
                if (cnt == 95) dec_par = tx;
`endif
                if (cnt == STOP_CENTER) begin
                    check("dec_stop", tx, 1'b1);
                    dec_q.push_back(sh);
                    act = 1'b0;
                end
            end
        end
    end

    logic wave [0:399];

    // From the first clock with tx low, count clocks until busy drops.
    task automatic measure(output int len);
        int n;
        n = 0;
        len = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            timeout("measure_start");
            return;
        end
        wave[0] = tx;
        while (busy !== 1'b0 && len < 399) begin
            @(negedge clk);
            len++;
            wave[len] = tx;
        end
        if (len >= 399) timeout("measure_busy");
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with byte_valid still high.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout("send_ready");
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout("wait_idle");
        repeat (3) @(negedge clk);
    endtask

    int len;
    logic [9:0] pat55;
    int bad;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        pat55 = 10'b1010101010;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // idle after reset
        repeat (50) @(negedge clk);
        check("t1_tx", tx, 1'b1);
        check("t1_ready", bus.byte_ready, 1'b1);
        check("t1_busy", busy, 1'b0);

        // single 0x55 frame
        fork
            measure(len);
            begin
                send(8'h55);
                bus.byte_valid = 1'b0;
            end
        join
        check("t2_len", len, SYMS * CYC);
        for (int s = 0; s < 9; s++) begin
            bad = 0;
            for (int j = 0; j < CYC; j++) if (wave[s * CYC + j] !== pat55[s]) bad++;
            check($sformatf("t2_sym%0d_bad_clocks", s), bad, 0);
        end
        check("t2_stop", wave[(SYMS - 1) * CYC], 1'b1);
        wait_idle();
        check("t2_dec_count", dec_q.size(), 1);
        if (dec_q.size() == 1) check("t2_dec0", dec_q[0], 8'h55);
        dec_q.delete();

        // back to back with valid held
        fork
            measure(len);
            begin
                send(8'hA3);
                send(8'h0F);
                bus.byte_valid = 1'b0;
            end
        join
        check("t3_len", len, 2 * SYMS * CYC);
        wait_idle();
        check("t3_dec_count", dec_q.size(), 2);
        if (dec_q.size() == 2) begin
            check("t3_dec0", dec_q[0], 8'hA3);
            check("t3_dec1", dec_q[1], 8'h0F);
        end
        dec_q.delete();

        // three queued bytes, third waits for the holding register
        fork
            measure(len);
            begin
                send(8'h12);
                send(8'h34);
                send(8'h56);
                bus.byte_valid = 1'b0;
            end
        join
        check("t4_len", len, 3 * SYMS * CYC);
        wait_idle();
        check("t4_dec_count", dec_q.size(), 3);
        if (dec_q.size() == 3) begin
            check("t4_dec0", dec_q[0], 8'h12);
            check("t4_dec1", dec_q[1], 8'h34);
            check("t4_dec2", dec_q[2], 8'h56);
        end
        dec_q.delete();

        // reset in the middle of a 0x00 frame
        send(8'h00);
        bus.byte_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (tx !== 1'b0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) timeout("t5_start");
        end
        repeat (35) @(negedge clk);
        check("t5_pre_tx", tx, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_ready", bus.byte_ready, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_post_tx", tx, 1'b1);
        check("t5_post_ready", bus.byte_ready, 1'b1);
        check("t5_post_busy", busy, 1'b0);
        check("t5_dec_count", dec_q.size(), 0);
        dec_q.delete();

`ifdef BOOT_UART_TX_PARITY_EN
        // parity symbol
        fork
            measure(len);
            begin
                send(8'h07);
                bus.byte_valid = 1'b0;
            end
        join
        check("t6_len", len, 110);
        check("t6_par07", wave[95], 1'b1);
        wait_idle();
        check("t6_decpar07", dec_par, 1'b1);
        if (dec_q.size() == 1) check("t6_dec07", dec_q[0], 8'h07);
        else check("t6_dec07_count", dec_q.size(), 1);
        dec_q.delete();
        fork
            measure(len);
            begin
                send(8'h03);
                bus.byte_valid = 1'b0;
            end
        join
        check("t6_par03", wave[95], 1'b0);
        wait_idle();
        check("t6_decpar03", dec_par, 1'b0);
        dec_q.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
